// File: rtl/sample_feeder.sv
// Consumer side of the sine_reader handshake: prefetches samples into a small FIFO
// and releases one per codec tick. Optional SAMPLE_FEEDER_VOLUME_EN adds an arithmetic volume shift.
module sample_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int SW      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   flush,
    output logic                   generate_next,
    input  logic                   sample_ready,
    input  logic [SW-1:0]          sample,
    input  logic                   sample_tick,
`ifdef SAMPLE_FEEDER_VOLUME_EN
    input  logic [3:0]             volume_shift,
`endif
    output logic [SW-1:0]          dac_sample,
    output logic                   dac_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   underflow,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic          issue;
    logic          push;
    logic          pop;
    logic          tick_uf;
    logic          to_err;

    logic [SW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [SW-1:0] pop_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            generate_next <= 1'b0;
        end else begin
            state         <= state_d;
            timer         <= timer_d;
            generate_next <= issue;
        end
    end

    // Flush wins over a coincident response in WAIT; DISCARD then swallows the stale reply.
    always_comb begin
        state_d = state;
        timer_d = timer;
        issue   = 1'b0;
        push    = 1'b0;
        to_err  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !flush && (fifo_count < DEPTH_C)) begin
                    issue   = 1'b1;
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer + TW'(1);
                if (flush) begin
                    state_d = DISCARD;
                end else if (sample_ready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (timer == TO_LAST) begin
                    to_err  = 1'b1;
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                timer_d = timer + TW'(1);
                if (sample_ready || (timer >= TO_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop     = sample_tick && !flush && (fifo_count != '0);
    assign tick_uf = sample_tick && (flush || (fifo_count == '0));

`ifdef SAMPLE_FEEDER_VOLUME_EN
    assign pop_data = $signed(mem[rd_ptr]) >>> volume_shift;
`else
    assign pop_data = mem[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            dac_sample  <= '0;
            dac_valid   <= 1'b0;
            underflow   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            dac_valid <= pop;
            if (pop) begin
                dac_sample <= pop_data;
            end
            if (tick_uf) begin
                underflow <= 1'b1;
            end
            if (to_err) begin
                timeout_err <= 1'b1;
            end
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CW'(1);
                    2'b01:   fifo_count <= fifo_count - CW'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

endmodule
